// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: two-CPU round-robin arbiter for the shared RAM port, data over instruction per CPU.
// Optional MEM_ARB_PERF_EN adds saturating per-CPU grant and stall counters.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module mem_rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int ADDR_W = 32
`ifdef MEM_ARB_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CPUS-1:0]              iREN,
    input  logic [CPUS-1:0][ADDR_W-1:0]  iaddr,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0][ADDR_W-1:0]  daddr,
    input  logic [CPUS-1:0][ADDR_W-1:0]  dstore,
    output logic [CPUS-1:0]              iwait,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][ADDR_W-1:0]  iload,
    output logic [CPUS-1:0][ADDR_W-1:0]  dload,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [ADDR_W-1:0]            ramaddr,
    output logic [ADDR_W-1:0]            ramstore,
    input  logic [ADDR_W-1:0]            ramload,
    input  ramstate_t                    ramstate
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CPUS-1:0][CNT_W-1:0]   grant_cnt,
    output logic [CPUS-1:0][CNT_W-1:0]   stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    typedef enum logic [1:0] {D_WR, D_RD, I_RD} src_t;

    state_t state;
    src_t gsrc, wsrc;
    logic gcpu, rr_last, win, g_req, active, done;
    logic [CPUS-1:0] req, own;

    assign req = iREN | dREN | dWEN;
    // On a tie the CPU that was not served last wins.
    assign win = (req[0] && req[1]) ? ~rr_last : req[1];
    assign wsrc = dWEN[win] ? D_WR : dREN[win] ? D_RD : I_RD;
    assign g_req = gsrc == D_WR ? dWEN[gcpu] : gsrc == D_RD ? dREN[gcpu] : iREN[gcpu];
    // Dropping the granted request aborts the access in the same cycle.
    assign active = state == GRANT && g_req && !RST;
    assign done = active && ramstate == ACCESS;
    assign ramWEN = active && gsrc == D_WR;
    assign ramREN = active && gsrc != D_WR;
    assign ramaddr = !active ? '0 : gsrc == I_RD ? iaddr[gcpu] : daddr[gcpu];
    assign ramstore = active ? dstore[gcpu] : '0;

    always_comb begin
        for (int c = 0; c < CPUS; c++) begin
            own[c] = active && gcpu == 1'(c);
            iwait[c] = !(own[c] && gsrc == I_RD && ramstate == ACCESS);
            dwait[c] = !(own[c] && gsrc != I_RD && ramstate == ACCESS);
            iload[c] = (own[c] && gsrc == I_RD) ? ramload : '0;
            dload[c] = (own[c] && gsrc != I_RD) ? ramload : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            rr_last <= 1'b1;
            gcpu <= 1'b0;
            gsrc <= D_WR;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    gcpu <= win;
                    gsrc <= wsrc;
                    state <= GRANT;
                end
                GRANT: if (!g_req) state <= IDLE;
                else if (ramstate == ACCESS) begin
                    state <= RELEASE;
                    rr_last <= gcpu;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge CLK) begin
        for (int c = 0; c < CPUS; c++) begin
            if (RST) begin
                grant_cnt[c] <= '0;
                stall_cnt[c] <= '0;
            end else begin
                if (done && own[c] && !(&grant_cnt[c])) grant_cnt[c] <= grant_cnt[c] + 1'b1;
                if (req[c] && !(done && own[c]) && !(&stall_cnt[c])) stall_cnt[c] <= stall_cnt[c] + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed self-checking bench for mem_rr_arbiter (covers MEM_ARB_PERF_EN when defined).
module tb_mem_rr_arbiter;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    logic [1:0] iREN, dREN, dWEN, iwait, dwait;
    logic [1:0][31:0] iaddr, daddr, dstore, iload, dload;
    logic ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    ramstate_t ramstate;
`ifdef MEM_ARB_PERF_EN
    logic [1:0][15:0] grant_cnt, stall_cnt;
`endif
    int vectors = 0;
    int miscompares = 0;

    mem_rr_arbiter dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARB_PERF_EN
        , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        step; step;
        vectors++; if ({iwait, dwait, ramREN, ramWEN} !== 6'b111100) begin miscompares++; $display("FAIL reset_ctl got %b want 111100", {iwait, dwait, ramREN, ramWEN}); end
        vectors++; if ({iload, dload, ramaddr, ramstore} !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", {iload, dload, ramaddr, ramstore}); end
        RST = 1'b0; step;
        vectors++; if ({iwait, dwait, ramREN, ramWEN} !== 6'b111100) begin miscompares++; $display("FAIL idle_ctl got %b want 111100", {iwait, dwait, ramREN, ramWEN}); end
    endtask

    task automatic test_single_read;
        iREN[0] = 1'b1; iaddr[0] = 32'h100;
        #1;
        vectors++; if (ramREN !== 1'b0) begin miscompares++; $display("FAIL sr_idle_ren got %b want 0", ramREN); end
        step;
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        vectors++; if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h100}) begin miscompares++; $display("FAIL sr_ram got %h want %h", {ramREN, ramWEN, ramaddr}, {2'b10, 32'h100}); end
        vectors++; if ({iwait, dwait} !== 4'b1011) begin miscompares++; $display("FAIL sr_wait got %b want 1011", {iwait, dwait}); end
        vectors++; if ({iload[1], iload[0], dload} !== {32'h0, 32'hDEADBEEF, 64'h0}) begin miscompares++; $display("FAIL sr_load got %h want DEADBEEF on iload0", {iload, dload}); end
        step;
        vectors++; if ({iwait, ramREN, iload[0]} !== {2'b11, 1'b0, 32'h0}) begin miscompares++; $display("FAIL sr_release got %h want 600000000", {iwait, ramREN, iload[0]}); end
        iREN = '0; ramstate = FREE;
        step;
        vectors++; if ({iwait, ramREN} !== 3'b110) begin miscompares++; $display("FAIL sr_idle got %b want 110", {iwait, ramREN}); end
    endtask

    task automatic test_write;
        dWEN[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'h1234; ramstate = BUSY;
        step;
        vectors++; if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h200, 32'h1234}) begin miscompares++; $display("FAIL wr_ram got %h want %h", {ramWEN, ramREN, ramaddr, ramstore}, {2'b10, 32'h200, 32'h1234}); end
        vectors++; if (dwait !== 2'b11) begin miscompares++; $display("FAIL wr_busy_wait got %b want 11", dwait); end
        ramstate = ACCESS; #1;
        vectors++; if ({dwait, iwait} !== 4'b0111) begin miscompares++; $display("FAIL wr_access_wait got %b want 0111", {dwait, iwait}); end
        step;
        dWEN = '0; dREN = '0; ramstate = FREE;
        step;
    endtask

    task automatic test_priority;
        iREN[0] = 1'b1; dREN[0] = 1'b1; iaddr[0] = 32'h100; daddr[0] = 32'h300; ramstate = BUSY;
        step;
        vectors++; if ({ramREN, ramaddr, dwait[0], iwait[0]} !== {1'b1, 32'h300, 2'b11}) begin miscompares++; $display("FAIL pri_data_first got %h want %h", {ramREN, ramaddr, dwait[0], iwait[0]}, {1'b1, 32'h300, 2'b11}); end
        step;
        ramstate = ACCESS; ramload = 32'hAAAA; #1;
        vectors++; if ({dwait[0], iwait[0], dload[0], iload[0]} !== {2'b01, 32'hAAAA, 32'h0}) begin miscompares++; $display("FAIL pri_data_done got %h want %h", {dwait[0], iwait[0], dload[0], iload[0]}, {2'b01, 32'hAAAA, 32'h0}); end
        step;
        dREN[0] = 1'b0; ramstate = BUSY;
        step;
        vectors++; if (ramREN !== 1'b0) begin miscompares++; $display("FAIL pri_idle_ren got %b want 0", ramREN); end
        step;
        vectors++; if ({ramREN, ramaddr} !== {1'b1, 32'h100}) begin miscompares++; $display("FAIL pri_instr_next got %h want %h", {ramREN, ramaddr}, {1'b1, 32'h100}); end
        ramstate = ACCESS; ramload = 32'h5555; #1;
        vectors++; if ({iwait[0], iload[0]} !== {1'b0, 32'h5555}) begin miscompares++; $display("FAIL pri_instr_done got %h want %h", {iwait[0], iload[0]}, {1'b0, 32'h5555}); end
        step;
        iREN = '0; ramstate = FREE;
        step;
    endtask

    task automatic test_round_robin;
        RST = 1'b1; step; RST = 1'b0;
        dREN = 2'b11; daddr[0] = 32'h400; daddr[1] = 32'h500;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] want_addr;
            logic [1:0] want_wait;
            want_addr = (k % 2 == 1) ? 32'h500 : 32'h400;
            want_wait = (k % 2 == 1) ? 2'b01 : 2'b10;
            ramstate = FREE;
            step;
            vectors++; if ({ramaddr, dwait} !== {want_addr, 2'b11}) begin miscompares++; $display("FAIL rr_grant%0d got %h want %h", k, {ramaddr, dwait}, {want_addr, 2'b11}); end
            ramstate = ACCESS; #1;
            vectors++; if (dwait !== want_wait) begin miscompares++; $display("FAIL rr_wait%0d got %b want %b", k, dwait, want_wait); end
            step;
            ramstate = FREE;
            step;
        end
        dREN = '0;
        step;
    endtask

    task automatic test_abort;
        dREN[0] = 1'b1; daddr[0] = 32'h600; daddr[1] = 32'h700; ramstate = BUSY;
        step;
        vectors++; if ({ramREN, ramaddr} !== {1'b1, 32'h600}) begin miscompares++; $display("FAIL ab_grant got %h want %h", {ramREN, ramaddr}, {1'b1, 32'h600}); end
        dREN[0] = 1'b0; #1;
        vectors++; if ({ramREN, ramWEN, dwait} !== 4'b0011) begin miscompares++; $display("FAIL ab_drop got %b want 0011", {ramREN, ramWEN, dwait}); end
        step;
        dREN = 2'b11;
        step;
        vectors++; if ({ramREN, ramaddr} !== {1'b1, 32'h600}) begin miscompares++; $display("FAIL ab_tie got %h want %h", {ramREN, ramaddr}, {1'b1, 32'h600}); end
        ramstate = ACCESS;
        step;
        dREN = '0; ramstate = FREE;
        step;
    endtask

    task automatic test_reset_in_grant;
        iREN[1] = 1'b1; iaddr[1] = 32'h800; ramstate = BUSY;
        step;
        vectors++; if ({ramREN, ramaddr} !== {1'b1, 32'h800}) begin miscompares++; $display("FAIL rg_grant got %h want %h", {ramREN, ramaddr}, {1'b1, 32'h800}); end
        RST = 1'b1;
        step;
        vectors++; if ({iwait, dwait, ramREN, ramWEN, ramaddr} !== {6'b111100, 32'h0}) begin miscompares++; $display("FAIL rg_idle got %h want %h", {iwait, dwait, ramREN, ramWEN, ramaddr}, {6'b111100, 32'h0}); end
`ifdef MEM_ARB_PERF_EN
        vectors++; if ({grant_cnt, stall_cnt} !== '0) begin miscompares++; $display("FAIL rg_cnt got %h want 0", {grant_cnt, stall_cnt}); end
`endif
        iREN = '0; RST = 1'b0; ramstate = FREE;
        step;
        vectors++; if ({iwait, ramREN} !== 3'b110) begin miscompares++; $display("FAIL rg_after got %b want 110", {iwait, ramREN}); end
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf;
        iREN[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step;
            ramstate = ACCESS;
            step;
            ramstate = FREE;
            step;
        end
        iREN = '0;
        step;
        vectors++; if ({grant_cnt[1], grant_cnt[0]} !== {16'd3, 16'd0}) begin miscompares++; $display("FAIL perf_grant got %h want 00030000", {grant_cnt[1], grant_cnt[0]}); end
        vectors++; if ({stall_cnt[1], stall_cnt[0]} !== {16'd6, 16'd0}) begin miscompares++; $display("FAIL perf_stall got %h want 00060000", {stall_cnt[1], stall_cnt[0]}); end
    endtask
`endif

    initial begin
        test_reset;
        test_single_read;
        test_write;
        test_priority;
        test_round_robin;
        test_abort;
        test_reset_in_grant;
`ifdef MEM_ARB_PERF_EN
        test_perf;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
